// File: rtl/snake_dir_input.sv
// ============================================================================
// snake_dir_input: synchronise and debounce the four direction buttons, latch
// the latest press and commit it on the game step tick, rejecting reversals.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snake_dir_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       tick,
  output logic [1:0] dir_o,
  output logic       turn_o,
  output logic       any_press_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit i of every button vector carries direction code i.
  logic [3:0]       btn_w;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       stable_dly_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press_w;
  logic [1:0]       req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic [1:0]       dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             any_q;
  logic             accept_w;

  assign btn_w = {right, left, down, up};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press_w  = stable_q & ~stable_dly_q;
  assign accept_w = tick && req_valid_q && (req_q != dir_q) &&
                    (req_q != {dir_q[1], ~dir_q[0]});

  // The tick judges the old request; a press in the same cycle becomes the
  // next pending request rather than being dropped.
  always_comb begin
    req_d       = req_q;
    req_valid_d = req_valid_q;
    dir_d       = dir_q;
    turn_d      = 1'b0;
    if (accept_w) begin
      dir_d  = req_q;
      turn_d = 1'b1;
    end
    if (tick) begin
      req_valid_d = 1'b0;
    end
    if (press_w != 4'b0000) begin
      req_valid_d = 1'b1;
      if (press_w[0])      req_d = 2'b00;
      else if (press_w[1]) req_d = 2'b01;
      else if (press_w[2]) req_d = 2'b10;
      else                 req_d = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      any_q        <= 1'b0;
      req_q        <= 2'b11;
      req_valid_q  <= 1'b0;
      dir_q        <= 2'b11;
      turn_q       <= 1'b0;
    end else begin
      sync1_q      <= btn_w;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      any_q        <= |stable_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      dir_q        <= dir_d;
      turn_q       <= turn_d;
    end
  end

  assign dir_o       = dir_q;
  assign turn_o      = turn_q;
  assign any_press_o = any_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_dir_input.sv
// ============================================================================
// tb_snake_dir_input: directed and randomised bench with a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_snake_dir_input;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       tick = 1'b0;
  logic [1:0] dir_o;
  logic       turn_o;
  logic       any_press_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  snake_dir_input #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .up(btn[0]), .down(btn[1]), .left(btn[2]), .right(btn[3]),
    .tick(tick), .dir_o(dir_o), .turn_o(turn_o), .any_press_o(any_press_o)
  );

  // Behavioural model: a stable level flips once the synchronised input has
  // disagreed with it for the last D samples since the previous flip.
  logic [3:0]   m_s1, m_s2, m_stable, m_prev;
  logic [D-1:0] m_win [4];
  int           m_fill [4];
  logic [1:0]   m_dir, m_req;
  logic         m_rv, m_turn, m_any;
  logic [3:0]   t_s2, t_st, t_press;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_prev = 0;
      for (int i = 0; i < 4; i++) begin m_win[i] = 0; m_fill[i] = 0; end
      m_dir = 2'b11; m_req = 2'b11; m_rv = 0; m_turn = 0; m_any = 0;
    end else begin
      t_s2 = m_s2; t_st = m_stable;
      t_press = m_stable & ~m_prev;
      m_prev = t_st;
      for (int i = 0; i < 4; i++) begin
        m_win[i] = {m_win[i][D-2:0], t_s2[i]};
        m_fill[i]++;
        if (m_fill[i] >= D && m_win[i] == {D{~t_st[i]}}) begin
          m_stable[i] = ~t_st[i];
          m_fill[i] = 0;
        end
      end
      m_s2 = m_s1; m_s1 = btn;
      m_any = |m_stable;
      m_turn = 0;
      if (tick && m_rv && m_req != m_dir && m_req != (m_dir ^ 2'b01)) begin
        m_dir = m_req; m_turn = 1;
      end
      if (t_press != 0) begin
        m_rv = 1;
        for (int i = 3; i >= 0; i--) if (t_press[i]) m_req = 2'(i);
      end else if (tick) begin
        m_rv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (dir_o !== m_dir || turn_o !== m_turn || any_press_o !== m_any) begin
        n_fail++;
        $display("FAIL model t=%0t dut dir=%b turn=%b any=%b, model dir=%b turn=%b any=%b",
                 $time, dir_o, turn_o, any_press_o, m_dir, m_turn, m_any);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [1:0] d, input logic t, input logic a);
    n_tests++;
    if (dir_o !== d || turn_o !== t || any_press_o !== a ||
        m_dir !== d || m_turn !== t || m_any !== a) begin
      n_fail++;
      $display("FAIL %s dut dir=%b turn=%b any=%b model dir=%b turn=%b any=%b want dir=%b turn=%b any=%b",
               nm, dir_o, turn_o, any_press_o, m_dir, m_turn, m_any, d, t, a);
    end
  endtask

  task automatic do_reset();
    reset = 1; step(1); reset = 0;
  endtask

  task automatic do_tick();
    tick = 1; step(1); tick = 0;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    btn = b; step(n); btn = 4'b0000; step(D + 3);
  endtask

  initial begin
    // Reset held 3 cycles with up asserted, then up keeps pressing.
    btn = 4'b0001;
    step(3);
    chk("reset_vals", 2'b11, 0, 0);
    chk_en = 1;
    reset = 0;
    step(6);
    chk("any_at_e6", 2'b11, 0, 1);
    step(1);
    do_tick();
    chk("up_commit", 2'b00, 1, 1);
    step(1);
    chk("turn_one_cycle", 2'b00, 0, 1);
    btn = 0; step(D + 4);

    // Glitch of 3 cycles on left is ignored.
    do_reset();
    btn = 4'b0100; step(3); btn = 0; step(8);
    chk("glitch_any", 2'b11, 0, 0);
    do_tick();
    chk("glitch_tick", 2'b11, 0, 0);

    // Reversal from right is rejected, then down is accepted.
    hold(4'b0100, 8);
    do_tick();
    chk("reverse_block", 2'b11, 0, 0);
    do_tick();
    chk("req_cleared", 2'b11, 0, 0);
    hold(4'b0010, 8);
    do_tick();
    chk("down_commit", 2'b01, 1, 0);

    // Latest press wins.
    do_reset();
    hold(4'b0001, 8);
    hold(4'b0010, 8);
    do_tick();
    chk("latest_wins", 2'b01, 1, 0);

    // Simultaneous up and left: up has priority.
    do_reset();
    hold(4'b0101, 8);
    do_tick();
    chk("priority", 2'b00, 1, 0);

    // Press detected in the tick cycle: tick sees nothing, next tick applies.
    do_reset();
    btn = 4'b0001;
    step(6);
    do_tick();
    chk("collide_tick", 2'b11, 0, 1);
    step(1);
    do_tick();
    chk("collide_next", 2'b00, 1, 1);
    btn = 0; step(D + 4);

    // Reset with a pending request and a partial debounce count.
    do_reset();
    hold(4'b0010, 8);
    btn = 4'b1000; step(3);
    reset = 1; step(1); reset = 0; btn = 0;
    chk("mid_reset", 2'b11, 0, 0);
    do_tick();
    chk("mid_reset_tick", 2'b11, 0, 0);

    // Randomised phase: held buttons, glitches, random ticks, rare resets.
    for (int k = 0; k < 400; k++) begin
      int len;
      btn = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        tick  = ($urandom_range(0, 5) == 0);
        reset = ($urandom_range(0, 299) == 0);
        step(1);
      end
      tick = 0; reset = 0;
    end
    btn = 0; step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
